dili_modalu_pipe: RTL and testbench

DILI_MODALU_PIPE -- requirements
Module: dili_modalu_pipe

---
 rtl/dili_pkg.sv | 22 ++
 rtl/dili_modred_lane.sv | 110 +++++++++++
 rtl/dili_modalu_pipe.sv | 82 ++++++++
 tb/tb_dili_modalu_pipe.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dili_pkg.sv
// Shared constants for the Dilithium modular ALU pipeline: default modulus,
// operand width, Barrett constant and operation encoding.
package dili_pkg;

    localparam int unsigned Q  = 8380417;
    localparam int unsigned QW = 23;

    typedef enum logic [1:0] {
        MODE_MUL  = 2'b00,
        MODE_ADD  = 2'b01,
        MODE_SUB  = 2'b10,
        MODE_PASS = 2'b11
    } mode_e;

    // mu = floor(2^(2*qw) / q)
    function automatic longint unsigned barrett_mu(input int unsigned q, input int unsigned qw);
        return (64'd1 << (2 * qw)) / 64'(q);
    endfunction

    localparam longint unsigned MU = barrett_mu(Q, QW);

endpackage

// File: rtl/dili_modred_lane.sv
// One lane of the modular ALU: range check, product/add/sub, Barrett
// reduction and final correction spread over four register stages.
module dili_modred_lane import dili_pkg::*; #(
    parameter int unsigned Q  = dili_pkg::Q,
    parameter int unsigned QW = dili_pkg::QW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          en_i,
    input  logic [1:0]    mode_i,
    input  logic [QW-1:0] a_i,
    input  logic [QW-1:0] b_i,
    output logic [QW-1:0] res_o,
    output logic          err_o
);

    localparam int unsigned PW   = 2 * QW;
    localparam int unsigned RW   = QW + 2;
    localparam logic [QW:0]   MU_L = (QW+1)'(barrett_mu(Q, QW));
    localparam logic [QW-1:0] Q_L  = QW'(Q);
    localparam logic [QW:0]   Q_W  = (QW+1)'(Q);
    localparam logic [RW-1:0] Q_R  = RW'(Q);

    mode_e         mode_c;
    logic          e_in_c;
    logic [PW-1:0] p_c;
    logic [QW:0]   sum_c;
    logic [QW:0]   dif_c;
    logic [QW-1:0] lin_c;
    logic [QW:0]   phi_c;
    logic [PW+1:0] t_c;
    logic [QW:0]   qe_c;
    logic [RW-1:0] r_c;
    logic [RW-1:0] r_a_c;
    logic [RW-1:0] r_b_c;
    logic [QW-1:0] res_d;

    logic [QW-1:0] a0_q, b0_q;
    mode_e         m0_q, m1_q, m2_q;
    logic          e0_q, e1_q, e2_q, err_q;
    logic [PW-1:0] p1_q;
    logic [QW-1:0] lin1_q, lin2_q, res_q;
    logic [RW-1:0] r2_q;

    assign mode_c = mode_e'(mode_i);
    assign e_in_c = (a_i >= Q_L) || ((mode_c != MODE_PASS) && (b_i >= Q_L));

    // Stage 1: full-width product and the single-correction add/sub/pass result
    assign p_c   = PW'(a0_q) * PW'(b0_q);
    assign sum_c = {1'b0, a0_q} + {1'b0, b0_q};
    assign dif_c = {1'b0, a0_q} - {1'b0, b0_q};

    always_comb begin
        lin_c = a0_q;
        case (m0_q)
            MODE_ADD: lin_c = (sum_c >= Q_W) ? QW'(sum_c - Q_W) : QW'(sum_c);
            MODE_SUB: lin_c = dif_c[QW] ? QW'(dif_c + Q_W) : QW'(dif_c);
            default:  lin_c = a0_q;
        endcase
    end

    // Stage 2: Barrett quotient estimate; remainder lands in [0, 3Q)
    assign phi_c = (QW+1)'(p1_q >> (QW - 1));
    assign t_c   = (PW+2)'(phi_c) * (PW+2)'(MU_L);
    assign qe_c  = (QW+1)'(t_c >> (QW + 1));
    assign r_c   = RW'(p1_q) - RW'(qe_c) * Q_R;

    // Stage 3: two conditional subtractions, error lanes forced to zero
    assign r_a_c = (r2_q >= Q_R) ? r2_q - Q_R : r2_q;
    assign r_b_c = (r_a_c >= Q_R) ? r_a_c - Q_R : r_a_c;
    assign res_d = e2_q ? '0 : ((m2_q == MODE_MUL) ? QW'(r_b_c) : lin2_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a0_q   <= '0;
            b0_q   <= '0;
            m0_q   <= MODE_MUL;
            e0_q   <= 1'b0;
            p1_q   <= '0;
            lin1_q <= '0;
            m1_q   <= MODE_MUL;
            e1_q   <= 1'b0;
            r2_q   <= '0;
            lin2_q <= '0;
            m2_q   <= MODE_MUL;
            e2_q   <= 1'b0;
            res_q  <= '0;
            err_q  <= 1'b0;
        end else if (en_i) begin
            a0_q   <= a_i;
            b0_q   <= b_i;
            m0_q   <= mode_c;
            e0_q   <= e_in_c;
            p1_q   <= p_c;
            lin1_q <= lin_c;
            m1_q   <= m0_q;
            e1_q   <= e0_q;
            r2_q   <= r_c;
            lin2_q <= lin1_q;
            m2_q   <= m1_q;
            e2_q   <= e1_q;
            res_q  <= res_d;
            err_q  <= e2_q;
        end
    end

    assign res_o = res_q;
    assign err_o = err_q;

endmodule

// File: rtl/dili_modalu_pipe.sv
// Multi-lane modular ALU with a 4-stage lock-step pipeline, global stall
// back-pressure, tag sideband and occupancy counter.
module dili_modalu_pipe import dili_pkg::*; #(
    parameter int unsigned Q     = dili_pkg::Q,
    parameter int unsigned QW    = dili_pkg::QW,
    parameter int unsigned LANES = 2,
    parameter int unsigned TAG_W = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    input  logic [1:0]          mode_i,
    input  logic [LANES*QW-1:0] a_i,
    input  logic [LANES*QW-1:0] b_i,
    input  logic [TAG_W-1:0]    tag_i,
    output logic                out_valid_o,
    input  logic                out_ready_i,
    output logic [LANES*QW-1:0] res_o,
    output logic [TAG_W-1:0]    tag_o,
    output logic [LANES-1:0]    rerr_o,
    output logic [2:0]          occ_o
);

    localparam int unsigned STAGES = 4;

    logic                               stall_c;
    logic                               accept_c;
    logic                               handshake_c;
    logic [STAGES-1:0]                  vld_q, vld_d;
    logic [STAGES-1:0][TAG_W-1:0]       tag_q, tag_d;
    logic [2:0]                         occ_q, occ_d;

    assign stall_c     = vld_q[STAGES-1] & ~out_ready_i;
    assign in_ready_o  = ~stall_c;
    assign accept_c    = in_valid_i & ~stall_c;
    assign handshake_c = vld_q[STAGES-1] & out_ready_i;

    // Whole pipe shifts as one; bubbles are only replaced when it advances
    always_comb begin
        vld_d = vld_q;
        tag_d = tag_q;
        occ_d = occ_q + 3'(accept_c) - 3'(handshake_c);
        if (!stall_c) begin
            vld_d = {vld_q[STAGES-2:0], accept_c};
            tag_d = {tag_q[STAGES-2:0], tag_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= '0;
            tag_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            tag_q <= tag_d;
            occ_q <= occ_d;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        dili_modred_lane #(
            .Q  (Q),
            .QW (QW)
        ) u_lane (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .en_i   (~stall_c),
            .mode_i (mode_i),
            .a_i    (a_i[i*QW +: QW]),
            .b_i    (b_i[i*QW +: QW]),
            .res_o  (res_o[i*QW +: QW]),
            .err_o  (rerr_o[i])
        );
    end

    assign out_valid_o = vld_q[STAGES-1];
    assign tag_o       = tag_q[STAGES-1];
    assign occ_o       = occ_q;

endmodule

// File: tb/tb_dili_modalu_pipe.sv
// Bench for dili_modalu_pipe: directed vector table, back-pressure and reset
// sequences, and randomized traffic against a plain-arithmetic model.
module tb_dili_modalu_pipe;

    localparam int unsigned Q     = 8380417;
    localparam int unsigned QW    = 23;
    localparam int unsigned LANES = 2;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned DW    = LANES * QW;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [1:0]       mode_i;
    logic [DW-1:0]    a_i;
    logic [DW-1:0]    b_i;
    logic [TAG_W-1:0] tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [DW-1:0]    res_o;
    logic [TAG_W-1:0] tag_o;
    logic [LANES-1:0] rerr_o;
    logic [2:0]       occ_o;

    dili_modalu_pipe #(
        .Q     (Q),
        .QW    (QW),
        .LANES (LANES),
        .TAG_W (TAG_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .mode_i      (mode_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .tag_i       (tag_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .res_o       (res_o),
        .tag_o       (tag_o),
        .rerr_o      (rerr_o),
        .occ_o       (occ_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]    mode;
        logic [QW-1:0] a0, a1, b0, b1;
        logic [QW-1:0] r0, r1;
        logic [1:0]    rerr;
    } vec_t;

    typedef struct {
        logic [DW-1:0]    res;
        logic [LANES-1:0] rerr;
        logic [TAG_W-1:0] tag;
    } exp_t;

    int               checks = 0;
    int               errors = 0;
    int               n_out = 0;
    int               occ_peak = 0;
    exp_t             exp_q[$];
    bit               hold_chk = 1'b0;
    logic [DW-1:0]    hold_res;
    logic [TAG_W-1:0] hold_tag;
    logic [LANES-1:0] hold_rerr;
    vec_t             vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic per lane
    function automatic exp_t model(input logic [1:0] md, input logic [DW-1:0] a,
                                   input logic [DW-1:0] b, input logic [TAG_W-1:0] tg);
        exp_t e;
        e.tag  = tg;
        e.res  = '0;
        e.rerr = '0;
        for (int i = 0; i < LANES; i++) begin
            longint unsigned av, bv, r;
            av = 64'(a[i*QW +: QW]);
            bv = 64'(b[i*QW +: QW]);
            r  = 0;
            if (av >= Q || (md != 2'b11 && bv >= Q)) begin
                e.rerr[i] = 1'b1;
            end else begin
                case (md)
                    2'b00:   r = (av * bv) % Q;
                    2'b01:   r = (av + bv) % Q;
                    2'b10:   r = (av + Q - bv) % Q;
                    default: r = av;
                endcase
            end
            e.res[i*QW +: QW] = QW'(r);
        end
        return e;
    endfunction

    function automatic logic [QW-1:0] rnd_op();
        int unsigned s;
        s = $urandom_range(0, 19);
        if (s == 0) return QW'($urandom_range(Q, (1 << QW) - 1));
        if (s == 1) return QW'(Q - 1);
        if (s == 2) return '0;
        return QW'($urandom_range(0, Q - 1));
    endfunction

    // One clock of traffic with scoreboard, occupancy, ready and hold checks
    task automatic step(input bit iv, input bit ordy, input logic [1:0] md,
                        input logic [DW-1:0] a, input logic [DW-1:0] b,
                        input logic [TAG_W-1:0] tg);
        bit   acc, hs;
        exp_t e;
        @(posedge clk_i);
        #1;
        check("occ", 64'(occ_o), 64'(exp_q.size()));
        if (hold_chk) begin
            check("hold_valid", 64'(out_valid_o), 64'd1);
            check("hold_res", 64'(res_o), 64'(hold_res));
            check("hold_tag", 64'(tag_o), 64'(hold_tag));
            check("hold_rerr", 64'(rerr_o), 64'(hold_rerr));
        end
        in_valid_i  = iv;
        out_ready_i = ordy;
        mode_i      = md;
        a_i         = a;
        b_i         = b;
        tag_i       = tg;
        #1;
        check("in_ready", 64'(in_ready_o), 64'(!(out_valid_o && !ordy)));
        hs  = out_valid_o && ordy;
        acc = iv && in_ready_o;
        if (hs) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("res", 64'(res_o), 64'(e.res));
                check("rerr", 64'(rerr_o), 64'(e.rerr));
                check("tag", 64'(tag_o), 64'(e.tag));
                n_out++;
            end
        end
        if (acc) exp_q.push_back(model(md, a, b, tg));
        hold_chk  = out_valid_o && !ordy;
        hold_res  = res_o;
        hold_tag  = tag_o;
        hold_rerr = rerr_o;
        if (int'(occ_o) > occ_peak) occ_peak = int'(occ_o);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            step(1'b0, 1'b1, 2'b00, '0, '0, '0);
            n++;
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int base;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        mode_i      = '0;
        a_i         = '0;
        b_i         = '0;
        tag_i       = '0;

        vecs[0] = '{2'b00, 23'd8380416, 23'd8380416, 23'd8380416, 23'd2, 23'd1, 23'd8380415, 2'b00};
        vecs[1] = '{2'b00, 23'd4194304, 23'd3, 23'd2, 23'd5, 23'd8191, 23'd15, 2'b00};
        vecs[2] = '{2'b01, 23'd8380416, 23'd100, 23'd1, 23'd200, 23'd0, 23'd300, 2'b00};
        vecs[3] = '{2'b10, 23'd0, 23'd10, 23'd1, 23'd3, 23'd8380416, 23'd7, 2'b00};
        vecs[4] = '{2'b11, 23'd123, 23'd8380417, 23'd8380422, 23'd0, 23'd123, 23'd0, 2'b10};
        vecs[5] = '{2'b00, 23'd8380417, 23'd3, 23'd5, 23'd4, 23'd0, 23'd12, 2'b01};
        vecs[6] = '{2'b10, 23'd5, 23'd1, 23'd8388607, 23'd8380416, 23'd0, 23'd2, 2'b01};
        vecs[7] = '{2'b01, 23'd4190000, 23'd4190000, 23'd4190417, 23'd4190416, 23'd0, 23'd8380416, 2'b00};

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_valid", 64'(out_valid_o), 64'd0);
        check("rst_occ", 64'(occ_o), 64'd0);
        check("rst_res", 64'(res_o), 64'd0);
        check("rst_tag", 64'(tag_o), 64'd0);
        check("rst_rerr", 64'(rerr_o), 64'd0);
        check("rst_in_ready", 64'(in_ready_o), 64'd1);
        rst_ni      = 1'b1;
        out_ready_i = 1'b1;

        // Directed vectors, one beat at a time with latency measurement
        for (int i = 0; i < 8; i++) begin
            mode_i     = vecs[i].mode;
            a_i        = {vecs[i].a1, vecs[i].a0};
            b_i        = {vecs[i].b1, vecs[i].b0};
            tag_i      = TAG_W'(8'hA0 + i);
            in_valid_i = 1'b1;
            @(posedge clk_i);
            #1;
            in_valid_i = 1'b0;
            lat = 1;
            while (!out_valid_o && lat < 12) begin
                @(posedge clk_i);
                #1;
                lat++;
            end
            check($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            check($sformatf("v%0d_res0", i), 64'(res_o[QW-1:0]), 64'(vecs[i].r0));
            check($sformatf("v%0d_res1", i), 64'(res_o[DW-1:QW]), 64'(vecs[i].r1));
            check($sformatf("v%0d_rerr", i), 64'(rerr_o), 64'(vecs[i].rerr));
            check($sformatf("v%0d_tag", i), 64'(tag_o), 64'(8'hA0 + i));
        end
        @(posedge clk_i);
        #1;
        hold_chk = 1'b0;

        // Eight back-to-back beats, tags 0..7
        base     = n_out;
        occ_peak = 0;
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 2'b00, {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()}, TAG_W'(i));
        drain();
        check("b2b_count", 64'(n_out - base), 64'd8);
        check("b2b_occ_peak", 64'(occ_peak), 64'd4);

        // Fill the pipe, then hold out_ready low for five cycles
        base = n_out;
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'b0, 2'(i), {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()}, TAG_W'(8'h40 + i));
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b0, 2'b01, {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()}, TAG_W'(8'h50 + i));
        drain();
        check("stall_count", 64'(n_out - base), 64'd4);

        // Randomized traffic with random back-pressure
        for (int i = 0; i < 300; i++)
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), 2'($urandom_range(0, 3)),
                 {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()}, TAG_W'($urandom));
        drain();

        // Reset with three beats in flight; they must never appear
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 2'b01, {rnd_op(), rnd_op()}, {rnd_op(), rnd_op()}, TAG_W'(8'h70 + i));
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("pre_rst_occ", 64'(occ_o), 64'd3);
        rst_ni = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid_o), 64'd0);
        check("mid_rst_occ", 64'(occ_o), 64'd0);
        check("mid_rst_res", 64'(res_o), 64'd0);
        check("mid_rst_tag", 64'(tag_o), 64'd0);
        check("mid_rst_rerr", 64'(rerr_o), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready_o), 64'd1);
        exp_q.delete();
        hold_chk = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        check("in_rst_out_valid", 64'(out_valid_o), 64'd0);
        rst_ni = 1'b1;
        base = n_out;
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, 2'b00, '0, '0, '0);
        step(1'b1, 1'b1, 2'b01, {23'd8380416, 23'd7}, {23'd1, 23'd9}, 8'h99);
        drain();
        check("post_rst_count", 64'(n_out - base), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
